// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl : stall/flush scheduler (mem wait > taken branch > load-use)
// Optional perf counters enabled by defining STALL_PERF_CNT_EN.  Revision 1.0
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int MEM_TIMEOUT  = 16,
    parameter int FLUSH_CYCLES = 2
`ifdef STALL_PERF_CNT_EN
    ,
    parameter int CNT_W        = 32
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic                  id_rs1_used,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_rd_we,
    input  logic                  ex_is_load,
    input  logic                  ex_branch_tkn,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic [4:0]            stall,
    output logic                  hold_id_ex,
    output logic                  flush_if_id,
    output logic                  mem_timeout,
    output logic [1:0]            state_o
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_cycles
`endif
);

    localparam int                WAIT_W       = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] C_WAIT_ONE   = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] C_WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);
    localparam logic [2:0]        C_FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
    localparam logic [4:0]        C_STALL_MEM  = 5'b11011;
    localparam logic [4:0]        C_STALL_BR   = 5'b00100;
    localparam logic [4:0]        C_STALL_LU   = 5'b00111;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [2:0]        flush_cnt_q, flush_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;

    logic              w_load_use;
    logic              w_mem_stall;
    logic [4:0]        w_stall;
    logic              w_hold;
    logic              w_flush;

    assign w_load_use  = ex_is_load && ex_rd_we && (ex_rd_addr != '0) &&
                         ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                          (id_rs2_used && (id_rs2_addr == ex_rd_addr)));
    assign w_mem_stall = mem_req && !mem_ready;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        mem_timeout_d = mem_timeout_q;
        w_stall       = '0;
        w_hold        = 1'b0;
        w_flush       = 1'b0;

        case (state_q)
            MEM_WAIT: begin
                // EX is frozen here, so branch and load-use are not looked at.
                if (mem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == C_WAIT_MAX) begin
                    mem_timeout_d = 1'b1;
                    state_d       = RUN;
                    wait_cnt_d    = '0;
                end else begin
                    w_stall    = C_STALL_MEM;
                    w_hold     = 1'b1;
                    wait_cnt_d = wait_cnt_q + C_WAIT_ONE;
                end
            end

            FLUSH: begin
                // A memory wait here drops the remaining flushes; the branch already redirected.
                if (w_mem_stall) begin
                    w_stall    = C_STALL_MEM;
                    w_hold     = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = C_WAIT_ONE;
                end else begin
                    w_flush     = 1'b1;
                    w_stall     = C_STALL_BR;
                    flush_cnt_d = flush_cnt_q - 3'd1;
                    if (flush_cnt_q == 3'd1) begin
                        state_d = RUN;
                    end
                end
            end

            default: begin
                if (w_mem_stall) begin
                    w_stall    = C_STALL_MEM;
                    w_hold     = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = C_WAIT_ONE;
                end else if (ex_branch_tkn) begin
                    w_flush = 1'b1;
                    w_stall = C_STALL_BR;
                    if (FLUSH_CYCLES > 1) begin
                        state_d     = FLUSH;
                        flush_cnt_d = C_FLUSH_INIT;
                    end
                end else if (w_load_use) begin
                    w_stall = C_STALL_LU;
                end
                // Unused encoding behaves as RUN for one cycle, then recovers.
                if (state_q != RUN) begin
                    state_d     = RUN;
                    wait_cnt_d  = '0;
                    flush_cnt_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            flush_cnt_q   <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign stall       = reset ? 5'b00000 : w_stall;
    assign hold_id_ex  = reset ? 1'b0 : w_hold;
    assign flush_if_id = reset ? 1'b0 : w_flush;
    assign mem_timeout = reset ? 1'b0 : mem_timeout_q;
    assign state_o     = reset ? 2'b00 : state_q;

`ifdef STALL_PERF_CNT_EN
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_cycles_q, flush_cycles_d;
    logic             w_stall_evt;

    assign w_stall_evt = (|stall[1:0]) || hold_id_ex;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_cycles_d = flush_cycles_q;
        if (w_stall_evt && (stall_cycles_q != C_CNT_MAX)) begin
            stall_cycles_d = stall_cycles_q + C_CNT_ONE;
        end
        if (flush_if_id && (flush_cycles_q != C_CNT_MAX)) begin
            flush_cycles_d = flush_cycles_q + C_CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_cycles_q <= flush_cycles_d;
        end
    end

    assign stall_cycles = reset ? '0 : stall_cycles_q;
    assign flush_cycles = reset ? '0 : flush_cycles_q;
`endif

endmodule
`default_nettype wire
